// File: rtl/rx_link_ack_generator_pkg.sv
// Shared types for the receive-side link: flit layout, response entries and FIFO states.
package rx_link_ack_generator_pkg;

  localparam int FLIT_W = 64;
  localparam int TXN_W  = 12;
  localparam int VC_W   = 2;
  localparam int CODE_W = 8;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [TXN_W-1:0] txn_id;
    logic [47:0]      addr;
  } req_t;

  typedef union packed {
    req_t              req;
    logic [FLIT_W-1:0] raw;
  } flit_u;

  typedef enum logic {RSP_ACK, RSP_NACK} rsp_kind_e;

  typedef struct packed {
    rsp_kind_e         kind;
    logic [TXN_W-1:0]  txn_id;
    logic [CODE_W-1:0] code;
  } rsp_entry_t;

  localparam logic [CODE_W-1:0] ERR_CODE_PARITY = 8'h01;
  localparam logic [CODE_W-1:0] ERR_CODE_NONE   = 8'h00;

  typedef enum logic [1:0] {FIFO_EMPTY, FIFO_PARTIAL, FIFO_FULL} fifo_state_e;

  // Even parity: the flit together with its parity bit must XOR to zero.
  function automatic logic parity_bad(input flit_u flit, input logic parity);
    return ^{flit, parity};
  endfunction

endpackage

// File: rtl/rx_link_ack_generator_if.sv
// Signal bundle between the network ejection port, the local consumer and the transmitter's retransmit logic.
interface rx_link_ack_generator_if;
  import rx_link_ack_generator_pkg::*;

  // valid/ready: a transfer happens on a rising clk edge where both are 1; the
  // sender holds its payload stable while valid is high and ready is low.
  // The ack/error pair has no ready: each is a one-cycle pulse.
  logic              net_rx_valid;
  flit_u             net_rx_flit;
  logic [VC_W-1:0]   net_rx_vc_id;
  logic              net_rx_parity;
  logic              net_rx_ready;

  logic              out_valid;
  flit_u             out_flit;
  logic [VC_W-1:0]   out_vc_id;
  logic              out_ready;

  logic              ack_valid;
  logic [TXN_W-1:0]  ack_txn_id;
  logic              error_detected;
  logic [TXN_W-1:0]  error_txn_id;
  logic [CODE_W-1:0] error_code;

  logic [7:0]        rx_error_count;
  logic [7:0]        dup_count;
  logic [7:0]        fifo_level;

  modport slave (
    input  net_rx_valid, net_rx_flit, net_rx_vc_id, net_rx_parity, out_ready,
    output net_rx_ready, out_valid, out_flit, out_vc_id,
    output ack_valid, ack_txn_id, error_detected, error_txn_id, error_code,
    output rx_error_count, dup_count, fifo_level
  );

  modport master (
    output net_rx_valid, net_rx_flit, net_rx_vc_id, net_rx_parity, out_ready,
    input  net_rx_ready, out_valid, out_flit, out_vc_id,
    input  ack_valid, ack_txn_id, error_detected, error_txn_id, error_code,
    input  rx_error_count, dup_count, fifo_level
  );

endinterface

// File: rtl/rx_link_ack_generator_sync_fifo_sa.sv
// Show-ahead synchronous FIFO with occupancy count; head reads as 0 while empty.
module sync_fifo_sa
  import rx_link_ack_generator_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count,
  output fifo_state_e   state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  fifo_state_e   state_nxt;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (count_nxt == '0)                state_nxt = FIFO_EMPTY;
    else if (count_nxt == CW'(DEPTH))   state_nxt = FIFO_FULL;
    else                                state_nxt = FIFO_PARTIAL;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= FIFO_EMPTY;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  assert property (@(posedge clk) disable iff (!rst_n) !(push && state == FIFO_FULL));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && state == FIFO_EMPTY));

endmodule

// File: rtl/rx_link_ack_generator.sv
// Receive-side link endpoint: parity check, duplicate filtering against recent txn_ids,
// buffered delivery and one ack/NACK pulse per accepted flit.
module rx_link_ack_generator
  import rx_link_ack_generator_pkg::*;
#(
  parameter int DATA_DEPTH = 8,
  parameter int RSP_DEPTH  = 8,
  parameter int DUP_WINDOW = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  rx_link_ack_generator_if.slave  bus
);

  localparam int DCW   = $clog2(DATA_DEPTH + 1);
  localparam int RCW   = $clog2(RSP_DEPTH + 1);
  localparam int HPW   = (DUP_WINDOW > 1) ? $clog2(DUP_WINDOW) : 1;
  localparam int DW    = FLIT_W + VC_W;
  localparam int RSP_W = $bits(rsp_entry_t);

  logic              ready_en;
  logic              accept;
  logic              bad_par;
  logic              hist_hit;
  logic              is_dup;
  logic              is_good;
  logic [TXN_W-1:0]  rx_txn_id;

  logic [TXN_W-1:0]      hist_id [DUP_WINDOW];
  logic [DUP_WINDOW-1:0] hist_valid;
  logic [HPW-1:0]        hist_ptr;

  logic [DW-1:0]  data_head;
  logic [DCW-1:0] data_count;
  logic           data_empty;
  fifo_state_e    data_state;

  rsp_entry_t     rsp_push;
  rsp_entry_t     rsp_head;
  logic [RCW-1:0] rsp_count;
  logic           rsp_empty;
  fifo_state_e    rsp_state;

  logic [7:0] rx_err_q;
  logic [7:0] dup_q;

  // ready_en keeps net_rx_ready low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign bus.net_rx_ready = ready_en
                            && (data_count < DCW'(DATA_DEPTH))
                            && (rsp_count  < RCW'(RSP_DEPTH));
  assign accept    = bus.net_rx_valid && bus.net_rx_ready;
  assign rx_txn_id = bus.net_rx_flit.req.txn_id;
  assign bad_par   = parity_bad(bus.net_rx_flit, bus.net_rx_parity);

  always_comb begin
    hist_hit = 1'b0;
    for (int i = 0; i < DUP_WINDOW; i++) begin
      if (hist_valid[i] && (hist_id[i] == rx_txn_id)) hist_hit = 1'b1;
    end
  end

  assign is_dup  = !bad_par && hist_hit;
  assign is_good = !bad_par && !hist_hit;

  always_comb begin
    rsp_push.kind   = bad_par ? RSP_NACK : RSP_ACK;
    rsp_push.txn_id = rx_txn_id;
    rsp_push.code   = bad_par ? ERR_CODE_PARITY : ERR_CODE_NONE;
  end

  // Only clean deliveries enter history, so a corrupted copy never masks its resend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= '0;
      hist_ptr   <= '0;
      for (int i = 0; i < DUP_WINDOW; i++) hist_id[i] <= '0;
    end else if (accept && is_good) begin
      hist_id[hist_ptr]    <= rx_txn_id;
      hist_valid[hist_ptr] <= 1'b1;
      hist_ptr <= (hist_ptr == HPW'(DUP_WINDOW - 1)) ? '0 : hist_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_err_q <= '0;
      dup_q    <= '0;
    end else begin
      if (accept && bad_par && (rx_err_q != 8'hFF)) rx_err_q <= rx_err_q + 8'd1;
      if (accept && is_dup  && (dup_q    != 8'hFF)) dup_q    <= dup_q + 8'd1;
    end
  end

  sync_fifo_sa #(.W(DW), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && is_good),
    .push_data ({bus.net_rx_flit, bus.net_rx_vc_id}),
    .pop       (bus.out_valid && bus.out_ready),
    .head      (data_head),
    .empty     (data_empty),
    .count     (data_count),
    .state     (data_state)
  );

  // The transmitter cannot stall responses, so the head drains every cycle.
  sync_fifo_sa #(.W(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (rsp_push),
    .pop       (!rsp_empty),
    .head      (rsp_head),
    .empty     (rsp_empty),
    .count     (rsp_count),
    .state     (rsp_state)
  );

  assign bus.out_valid = !data_empty;
  assign bus.out_flit  = data_head[DW-1:VC_W];
  assign bus.out_vc_id = data_head[VC_W-1:0];

  assign bus.ack_valid      = !rsp_empty && (rsp_head.kind == RSP_ACK);
  assign bus.ack_txn_id     = bus.ack_valid ? rsp_head.txn_id : '0;
  assign bus.error_detected = !rsp_empty && (rsp_head.kind == RSP_NACK);
  assign bus.error_txn_id   = bus.error_detected ? rsp_head.txn_id : '0;
  assign bus.error_code     = bus.error_detected ? rsp_head.code : '0;

  assign bus.rx_error_count = rx_err_q;
  assign bus.dup_count      = dup_q;
  assign bus.fifo_level     = 8'(data_count);

  assert property (@(posedge clk) disable iff (!rst_n) (data_state == FIFO_EMPTY) == data_empty);
  assert property (@(posedge clk) disable iff (!rst_n) (rsp_state == FIFO_EMPTY) == rsp_empty);
  assert property (@(posedge clk) disable iff (!rst_n) !(bus.ack_valid && bus.error_detected));

endmodule

// File: tb/tb_rx_link_ack_generator.sv
// Directed bench for rx_link_ack_generator: vector table plus backpressure, history-window and reset sequences.
module tb_rx_link_ack_generator;
  import rx_link_ack_generator_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_link_ack_generator_if bus ();

  rx_link_ack_generator #(
    .DATA_DEPTH (8),
    .RSP_DEPTH  (8),
    .DUP_WINDOW (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] id;
    logic [1:0]  vc;
    logic        bad;
    logic        e_out;
    logic        e_ack;
    logic        e_err;
    logic [7:0]  e_rx;
    logic [7:0]  e_dup;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [65:0] exp_q[$];
  logic        sb_en = 1'b0;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic flit_u mk_flit(input logic [11:0] id);
    flit_u f;
    f.req.opcode = 4'h3;
    f.req.txn_id = id;
    f.req.addr   = {36'hABCDE0001, id};
    return f;
  endfunction

  function automatic logic [65:0] exp_word(input logic [11:0] id, input logic [1:0] vc);
    return {mk_flit(id), vc};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [11:0] id, input logic [1:0] vc, input logic bad);
    flit_u f;
    f = mk_flit(id);
    bus.net_rx_valid  = 1'b1;
    bus.net_rx_flit   = f;
    bus.net_rx_vc_id  = vc;
    bus.net_rx_parity = (^f) ^ bad;
  endtask

  task automatic idle();
    bus.net_rx_valid  = 1'b0;
    bus.net_rx_flit   = '0;
    bus.net_rx_vc_id  = '0;
    bus.net_rx_parity = 1'b0;
  endtask

  // Returns at posedge+1 of the cycle after the flit was accepted.
  task automatic send(input logic [11:0] id, input logic [1:0] vc, input logic bad);
    logic ok;
    ok = 1'b0;
    drive(id, vc, bad);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.net_rx_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("send_ready_within_budget", ok, 1'b1);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_vec(input vec_t v);
    chk("out_valid", bus.out_valid, v.e_out);
    if (v.e_out) chk("out_flit_vc", {bus.out_flit, bus.out_vc_id}, exp_word(v.id, v.vc));
    chk("ack_valid", bus.ack_valid, v.e_ack);
    chk("ack_txn_id", bus.ack_txn_id, v.e_ack ? v.id : 12'h000);
    chk("error_detected", bus.error_detected, v.e_err);
    chk("error_txn_id", bus.error_txn_id, v.e_err ? v.id : 12'h000);
    chk("error_code", bus.error_code, v.e_err ? 8'h01 : 8'h00);
    chk("rx_error_count", bus.rx_error_count, v.e_rx);
    chk("dup_count", bus.dup_count, v.e_dup);
    chk("fifo_level", bus.fifo_level, v.e_out ? 8'd1 : 8'd0);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- delivery scoreboard ----------------
  always @(negedge clk) begin
    if (sb_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_delivery", {bus.out_flit, bus.out_vc_id}, '0);
      else                   chk("sb_delivery_order", {bus.out_flit, bus.out_vc_id}, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t v1;
    vecs[0] = '{12'h005, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0};
    vecs[1] = '{12'h005, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0};
    vecs[2] = '{12'h00A, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0};
    vecs[3] = '{12'h00A, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1};
    vecs[4] = '{12'h005, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2};
    vecs[5] = '{12'h00A, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd2};
    vecs[6] = '{12'h7FF, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd2};
    vecs[7] = '{12'hFFF, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd2};

    idle();
    bus.out_ready = 1'b1;
    #2;
    chk("rst_net_rx_ready", bus.net_rx_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_ack_valid", bus.ack_valid, 1'b0);
    chk("rst_error_detected", bus.error_detected, 1'b0);
    chk("rst_fifo_level", bus.fifo_level, 8'd0);
    chk("rst_counters", {bus.rx_error_count, bus.dup_count}, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: each vector's results appear the cycle after it is accepted.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].id, vecs[i].vc, vecs[i].bad);
      @(negedge clk);
      chk("tbl_net_rx_ready", bus.net_rx_ready, 1'b1);
      if (i > 0) check_vec(vecs[i-1]);
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    check_vec(vecs[7]);

    // Backpressure: 10 flits against an 8-deep delivery FIFO.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    sb_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exp_word(12'h100 + 12'(i), 2'(i)));
      send(12'h100 + 12'(i), 2'(i), 1'b0);
    end
    drive(12'h108, 2'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low_when_full", bus.net_rx_ready, 1'b0);
      chk("bp_fifo_level_full", bus.fifo_level, 8'd8);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_bypass_ready", bus.net_rx_ready, 1'b0);
    @(posedge clk); #1;
    exp_q.push_back(exp_word(12'h108, 2'd0));
    send(12'h108, 2'd0, 1'b0);
    exp_q.push_back(exp_word(12'h109, 2'd1));
    send(12'h109, 2'd1, 1'b0);
    wait_drain("bp_all_delivered");
    chk("bp_fifo_level_empty", bus.fifo_level, 8'd0);
    @(posedge clk); #1;
    sb_en = 1'b0;

    // History window: 17 txns evict txn 0 but keep txn 16.
    reset_dut();
    @(posedge clk); #1;
    sb_en = 1'b1;
    for (int t = 0; t <= 16; t++) begin
      exp_q.push_back(exp_word(12'(t), 2'(t)));
      send(12'(t), 2'(t), 1'b0);
    end
    exp_q.push_back(exp_word(12'h000, 2'd0));
    send(12'h000, 2'd0, 1'b0);
    send(12'h010, 2'd0, 1'b0);
    wait_drain("win_deliveries");
    chk("win_dup_count", bus.dup_count, 8'd1);
    chk("win_rx_error_count", bus.rx_error_count, 8'd0);
    @(posedge clk); #1;
    sb_en = 1'b0;

    // Reset with buffered flits and a pending response.
    bus.out_ready = 1'b0;
    send(12'h300, 2'd1, 1'b0);
    send(12'h301, 2'd2, 1'b0);
    send(12'h302, 2'd3, 1'b0);
    chk("pre_rst_ack_pending", bus.ack_valid, 1'b1);
    chk("pre_rst_fifo_level", bus.fifo_level, 8'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out_flit", bus.out_flit, '0);
    chk("mid_rst_ack_valid", bus.ack_valid, 1'b0);
    chk("mid_rst_ack_txn_id", bus.ack_txn_id, 12'h000);
    chk("mid_rst_fifo_level", bus.fifo_level, 8'd0);
    chk("mid_rst_net_rx_ready", bus.net_rx_ready, 1'b0);
    chk("mid_rst_dup_count", bus.dup_count, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_stale_ack", bus.ack_valid, 1'b0);
      chk("post_rst_no_stale_flit", bus.out_valid, 1'b0);
    end
    @(posedge clk); #1;
    v1 = '{12'h005, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
    send(v1.id, v1.vc, v1.bad);
    @(negedge clk);
    check_vec(v1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
